crack_ctrl: RTL and testbench

- Brute-force key-search controller; acts as initiator on the arc4 en/rdy/key interface and as reader of the plaintext memory that arc4 writes.
- For each candidate key: starts one arc4 decryption, waits for completion, then scans pt memory.
- Plaintext is length-prefixed: pt[0] = length L, pt[1..L] = message.
- A key is accepted when every message byte is printable ASCII (0x20..0x7E). Sits between the top-level task controller and arc4/pt_mem.

---
 rtl/crack_ctrl.sv | 176 +++++++++++++++++
 tb/tb_crack_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/crack_ctrl.sv
// crack_ctrl: brute-force key-search controller.
// Launches arc4 once per candidate key, then scans the length-prefixed
// plaintext in pt_mem. A key is accepted when every message byte is
// printable ASCII (0x20..0x7E).
// Optional build macro CRACK_PERF_CNT_EN adds the keys_tried counter output.
module crack_ctrl #(
   parameter logic [23:0] KEY_START = 24'h000000,
   parameter logic [23:0] KEY_STEP  = 24'd1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   output logic        rdy,
   output logic [23:0] key,
   output logic        key_valid,
   output logic        arc4_en,
   input  logic        arc4_rdy,
   output logic [23:0] arc4_key,
   output logic        pt_sel,
   output logic [7:0]  pt_addr,
   input  logic [7:0]  pt_rddata
`ifdef CRACK_PERF_CNT_EN
   ,
   output logic [24:0] keys_tried
`endif
);

   typedef enum logic [3:0] {
      S_IDLE, S_LAUNCH, S_ARC4_BUSY, S_ARC4_WAIT, S_RD_LEN,
      S_LEN_WAIT, S_SCAN, S_NEXT, S_DONE
   } state_t;

   state_t      r_state;
   logic        r_rdy;
   logic [23:0] r_key;
   logic        r_key_valid;
   logic        r_arc4_en;
   logic [23:0] r_arc4_key;
   logic        r_pt_sel;
   logic [7:0]  r_pt_addr;
   logic [23:0] r_cand;
   logic [7:0]  r_len;
   logic [8:0]  r_idx;     // address currently presented; 9 bits so L=255 never wraps
   logic        r_found;

   logic [24:0] w_sum;
   logic        w_printable;
   logic        w_last;
   logic [8:0]  w_idx_nxt;
   logic        w_launch;

   assign w_sum       = {1'b0, r_cand} + {1'b0, KEY_STEP};
   assign w_printable = (pt_rddata >= 8'h20) && (pt_rddata <= 8'h7E);
   // Byte on pt_rddata belongs to address r_idx-1
   assign w_last      = ((r_idx - 9'd1) == {1'b0, r_len});
   assign w_idx_nxt   = r_idx + 9'd1;
   assign w_launch    = (r_state == S_LAUNCH) && arc4_rdy;

   assign rdy       = r_rdy;
   assign key       = r_key;
   assign key_valid = r_key_valid;
   assign arc4_en   = r_arc4_en;
   assign arc4_key  = r_arc4_key;
   assign pt_sel    = r_pt_sel;
   assign pt_addr   = r_pt_addr;

   // Search FSM with registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_rdy       <= 1'b1;
         r_key       <= '0;
         r_key_valid <= 1'b0;
         r_arc4_en   <= 1'b0;
         r_arc4_key  <= KEY_START;
         r_pt_sel    <= 1'b0;
         r_pt_addr   <= '0;
         r_cand      <= KEY_START;
         r_len       <= '0;
         r_idx       <= '0;
         r_found     <= 1'b0;
      end else begin
         r_arc4_en <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (en) begin
                  r_key_valid <= 1'b0;
                  r_cand      <= KEY_START;
                  r_arc4_key  <= KEY_START;
                  r_found     <= 1'b0;
                  r_rdy       <= 1'b0;
                  r_state     <= S_LAUNCH;
               end
            end
            S_LAUNCH: begin
               if (arc4_rdy) begin
                  r_arc4_en <= 1'b1;
                  r_state   <= S_ARC4_BUSY;
               end
            end
            // arc4 still shows rdy=1 in the cycle it samples en
            S_ARC4_BUSY: r_state <= S_ARC4_WAIT;
            S_ARC4_WAIT: begin
               if (arc4_rdy) begin
                  r_pt_sel  <= 1'b1;
                  r_pt_addr <= 8'd0;
                  r_state   <= S_RD_LEN;
               end
            end
            S_RD_LEN: r_state <= S_LEN_WAIT;
            S_LEN_WAIT: begin
               r_len <= pt_rddata;
               if (pt_rddata == 8'd0) begin
                  r_found  <= 1'b1;
                  r_pt_sel <= 1'b0;
                  r_state  <= S_DONE;
               end else begin
                  r_idx     <= 9'd1;
                  r_pt_addr <= 8'd1;
                  r_state   <= S_SCAN;
               end
            end
            S_SCAN: begin
               // At r_idx=1 the data is still the length byte, so skip the check
               if ((r_idx != 9'd1) && !w_printable) begin
                  r_pt_sel <= 1'b0;
                  r_state  <= S_NEXT;
               end else if ((r_idx != 9'd1) && w_last) begin
                  r_found  <= 1'b1;
                  r_pt_sel <= 1'b0;
                  r_state  <= S_DONE;
               end else begin
                  r_idx     <= w_idx_nxt;
                  r_pt_addr <= w_idx_nxt[7:0];
               end
            end
            S_NEXT: begin
               if (w_sum[24]) begin
                  r_state <= S_DONE;
               end else begin
                  r_cand     <= w_sum[23:0];
                  r_arc4_key <= w_sum[23:0];
                  r_state    <= S_LAUNCH;
               end
            end
            S_DONE: begin
               if (r_found) begin
                  r_key       <= r_cand;
                  r_key_valid <= 1'b1;
               end else begin
                  r_key_valid <= 1'b0;
               end
               r_rdy   <= 1'b1;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

`ifdef CRACK_PERF_CNT_EN
   logic [24:0] r_keys_tried;
   assign keys_tried = r_keys_tried;

   // Count arc4 launches of the current search
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_keys_tried <= '0;
      else if ((r_state == S_IDLE) && en)
         r_keys_tried <= '0;
      else if (w_launch)
         r_keys_tried <= r_keys_tried + 25'd1;
   end
`endif

endmodule

// File: tb/tb_crack_ctrl.sv
// tb_crack_ctrl: four crack_ctrl instances (different KEY_START/KEY_STEP)
// each driving a behavioural arc4 + pt_mem model whose plaintext is taken
// from a per-key table; results are compared with a search model.
`timescale 1ns/1ps
module tb_crack_ctrl;
   localparam int NI = 4;
   localparam logic [NI-1:0][23:0] KS = {24'hFFFFFF, 24'h000001, 24'hFFFFFE, 24'h000000};
   localparam logic [NI-1:0][23:0] KT = {24'd1, 24'd2, 24'd1, 24'd1};

   logic clk = 1'b0;
   logic rst_n;
   logic [NI-1:0]        en, rdy, kv, a_en, a_rdy, pt_sel;
   logic [NI-1:0][23:0]  key, a_key;
   logic [NI-1:0][7:0]   pt_addr, pt_rd, maxa;
   logic [NI-1:0][31:0]  pulses;
`ifdef CRACK_PERF_CNT_EN
   logic [NI-1:0][24:0]  ktried;
`endif
   logic [7:0] tab [0:31][0:255];
   int lat_max = 3;
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   // Plaintext produced by arc4 for key k (keys >= 32 never decrypt to text)
   function automatic logic [7:0] pt_byte(input logic [23:0] k, input logic [7:0] a);
      if (k < 24'd32) return tab[k[4:0]][a];
      return (a == 8'd0) ? 8'd2 : 8'h01;
   endfunction

   function automatic bit key_ok(input logic [23:0] k);
      int l;
      logic [7:0] b;
      l = int'(pt_byte(k, 8'd0));
      for (int j = 1; j <= l; j++) begin
         b = pt_byte(k, 8'(j));
         if (b < 8'h20 || b > 8'h7E) return 1'b0;
      end
      return 1'b1;
   endfunction

   for (genvar g = 0; g < NI; g++) begin : g_u
      logic        rdy_m;
      logic [23:0] lk;
      int          busy;
      int          pc;
      logic [7:0]  rd_m;
      logic [7:0]  mx;

      crack_ctrl #(.KEY_START(KS[g]), .KEY_STEP(KT[g])) u_dut (
         .clk(clk), .rst_n(rst_n), .en(en[g]), .rdy(rdy[g]), .key(key[g]),
         .key_valid(kv[g]), .arc4_en(a_en[g]), .arc4_rdy(a_rdy[g]),
         .arc4_key(a_key[g]), .pt_sel(pt_sel[g]), .pt_addr(pt_addr[g]),
         .pt_rddata(pt_rd[g])
`ifdef CRACK_PERF_CNT_EN
         , .keys_tried(ktried[g])
`endif
      );

      // arc4 + pt_mem model: random decrypt time, 1-cycle read latency
      always @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            rdy_m <= 1'b1; lk <= '0; busy <= 0; pc <= 0; rd_m <= '0; mx <= '0;
         end else begin
            if (a_en[g]) pc <= pc + 1;
            if (a_en[g] && rdy_m) begin
               rdy_m <= 1'b0;
               lk    <= a_key[g];
               busy  <= int'($urandom_range(lat_max, 1));
            end else if (!rdy_m) begin
               if (busy <= 1) rdy_m <= 1'b1;
               else busy <= busy - 1;
            end
            rd_m <= pt_byte(lk, pt_addr[g]);
            if (pt_sel[g] && lk == 24'd0 && pt_addr[g] > mx) mx <= pt_addr[g];
         end
      end
      assign a_rdy[g]  = rdy_m;
      assign pt_rd[g]  = rd_m;
      assign pulses[g] = 32'(pc);
      assign maxa[g]   = mx;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic fill_all(input logic [7:0] l, input logic [7:0] b);
      for (int k = 0; k < 32; k++)
         for (int a = 0; a < 256; a++)
            tab[k][a] = (a == 0) ? l : b;
   endtask

   // Search order per the rules: start, start+step, ... until a text key or past 24'hFFFFFF
   task automatic predict(input logic [23:0] st, input logic [23:0] sp,
                          output bit found, output logic [23:0] k, output int n);
      logic [24:0] c;
      c = {1'b0, st}; n = 0; found = 1'b0; k = '0;
      while (n < 200) begin
         n++;
         if (key_ok(c[23:0])) begin found = 1'b1; k = c[23:0]; break; end
         c = c + {1'b0, sp};
         if (c > 25'hFFFFFF) break;
      end
   endtask

   task automatic run_chk(input int i, input string tag, input bit spur);
      bit ef;
      logic [23:0] ek;
      int en_n, p0, cyc;
      predict(KS[i], KT[i], ef, ek, en_n);
      p0 = int'(pulses[i]);
      @(negedge clk); en[i] = 1'b1;
      @(negedge clk); en[i] = 1'b0;
      chk({tag, ".rdy_busy"}, 32'(rdy[i]), 32'd0);
      chk({tag, ".kv_clr"}, 32'(kv[i]), 32'd0);
      if (spur) begin
         repeat (3) @(negedge clk);
         en[i] = 1'b1;
         repeat (2) @(negedge clk);
         en[i] = 1'b0;
      end
      cyc = 0;
      while (!rdy[i] && cyc < 20000) begin @(negedge clk); cyc++; end
      chk({tag, ".done"}, 32'(rdy[i]), 32'd1);
      chk({tag, ".kv"}, 32'(kv[i]), 32'(ef));
      if (ef) chk({tag, ".key"}, 32'(key[i]), 32'(ek));
      chk({tag, ".pulses"}, 32'(int'(pulses[i]) - p0), 32'(en_n));
`ifdef CRACK_PERF_CNT_EN
      chk({tag, ".ktried"}, 32'(ktried[i]), 32'(en_n));
`endif
   endtask

   initial begin
      int cyc;
      en = '0;
      rst_n = 1'b0;
      fill_all(8'd2, 8'h01);
      #12;
      chk("rst.rdy", 32'(rdy[0]), 32'd1);
      chk("rst.key", 32'(key[0]), 32'd0);
      chk("rst.kv", 32'(kv[0]), 32'd0);
      chk("rst.arc4_en", 32'(a_en[0]), 32'd0);
      chk("rst.arc4_key1", 32'(a_key[1]), 32'hFFFFFE);
      chk("rst.pt_sel", 32'(pt_sel[0]), 32'd0);
      chk("rst.pt_addr", 32'(pt_addr[0]), 32'd0);
`ifdef CRACK_PERF_CNT_EN
      chk("rst.ktried", 32'(ktried[0]), 32'd0);
`endif
      @(negedge clk); rst_n = 1'b1;

      // "Hi" only for key 10, with en pulsed during the search
      fill_all(8'd2, 8'h01);
      tab[10][1] = 8'h48; tab[10][2] = 8'h69;
      run_chk(0, "hi", 1'b1);
      chk("hi.key_abs", 32'(key[0]), 32'h00000A);

      // L=0 everywhere: accept first key without scanning
      do_reset();
      fill_all(8'd0, 8'h01);
      run_chk(0, "zero", 1'b0);
      chk("zero.no_scan", 32'(maxa[0]), 32'd0);

      // Key space exhaustion near the top of the range
      do_reset();
      fill_all(8'd2, 8'h01);
      run_chk(1, "exh2", 1'b0);
      run_chk(3, "exh1", 1'b0);

      // Printable boundaries 0x20/0x7E, 0x7F rejected
      do_reset();
      fill_all(8'd3, 8'h41);
      tab[0][1] = 8'h20; tab[0][2] = 8'h7E; tab[0][3] = 8'h7F;
      tab[1][1] = 8'h20; tab[1][2] = 8'h7E; tab[1][3] = 8'h41;
      run_chk(0, "bound", 1'b0);
      chk("bound.key_abs", 32'(key[0]), 32'd1);

      // Bad first byte: early exit keeps reads at address <= 2
      do_reset();
      fill_all(8'd3, 8'h41);
      tab[0][1] = 8'h01; tab[1][0] = 8'd0;
      run_chk(0, "early", 1'b0);
      chk("early.maxaddr", 32'(maxa[0]), 32'd2);

      // L=255: last byte of key 0 bad, key 1 all printable
      do_reset();
      fill_all(8'd255, 8'h41);
      tab[0][255] = 8'h7F;
      run_chk(0, "l255", 1'b0);
      chk("l255.key_abs", 32'(key[0]), 32'd1);

      // Step 2 from key 1
      do_reset();
      fill_all(8'd2, 8'h01);
      tab[7][0] = 8'd0;
      run_chk(2, "step7", 1'b0);
      fill_all(8'd2, 8'h01);
      tab[6][0] = 8'd0; tab[31][0] = 8'd0;
      run_chk(2, "step6", 1'b0);

      // Randomized plaintext tables and arc4 latency
      for (int r = 0; r < 4; r++) begin
         lat_max = int'($urandom_range(6, 1));
         for (int k = 0; k < 32; k++) begin
            tab[k][0] = 8'($urandom_range(7, 0));
            for (int a = 1; a < 256; a++) begin
               case ($urandom % 10)
                  0: tab[k][a] = 8'h1F;
                  1: tab[k][a] = 8'h7F;
                  2: tab[k][a] = 8'h20;
                  3: tab[k][a] = 8'h7E;
                  default: tab[k][a] = 8'($urandom_range(8'h7E, 8'h20));
               endcase
            end
         end
         tab[31][0] = 8'd0;
         do_reset();
         run_chk(0, "rnd0", 1'b0);
         run_chk(2, "rnd2", 1'b0);
      end

      // Reset while waiting on arc4
      lat_max = 30;
      do_reset();
      fill_all(8'd2, 8'h01);
      tab[10][1] = 8'h48; tab[10][2] = 8'h69;
      @(negedge clk); en[0] = 1'b1;
      @(negedge clk); en[0] = 1'b0;
      cyc = 0;
      while (a_rdy[0] && cyc < 200) begin @(negedge clk); cyc++; end
      chk("mid.in_wait", 32'(a_rdy[0]), 32'd0);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("mid.rdy", 32'(rdy[0]), 32'd1);
      chk("mid.kv", 32'(kv[0]), 32'd0);
      chk("mid.arc4_en", 32'(a_en[0]), 32'd0);
      chk("mid.pt_sel", 32'(pt_sel[0]), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      lat_max = 3;
      run_chk(0, "post", 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
